cla_5_bit: RTL and testbench
============================

// Module: cla_5_bit
// PURPOSE
//   5-bit carry-lookahead adder: sum = a + b + c_in, with carry-out.
//   Carries are computed in parallel from generate/propagate terms, never rippled.
//   Datapath primitive for the divider's partial-remainder add/subtract stage.
//   Results are registered once for timing closure.
// PARAMETERS
//   WIDTH  5  operand width; fixed at 5, carry equations are written out for 5 bits
// PORTS
//   clk     input   1  single clock; all state updates on the rising edge
//   rst_n   input   1  asynchronous, active-low reset
//   a       input   5  operand A, unsigned
//   b       input   5  operand B, unsigned
//   c_in    input   1  carry-in
//   sum     output  5  registered (a + b + c_in) mod 32
//   c_out   output  1  registered carry-out, bit 5 of a + b + c_in
//   grp_p   output  1  registered group propagate, &(a ^ b)
//   grp_g   output  1  registered group generate, for cascading 5-bit blocks
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-low.
//   - Reset: while rst_n = 0, sum = 0, c_out = 0, grp_p = 0, grp_g = 0, independent of clk.
//   - Bit terms: p[i] = a[i] ^ b[i] and g[i] = a[i] & b[i], for i = 0..4.
//   - Carries: c[0] = c_in; c[i+1] = g[i] | p[i]&c[i].
//     Each c[i+1] is flattened to two-level sum-of-products over g, p and c_in.
//     For example, c[2] = g1 | p1&g0 | p1&p0&c_in. No carry depends on another computed carry.
//   - Sum: s[i] = p[i] ^ c[i].
//   - Carry-out and group terms: c_out = c[5]; grp_g = c[5] evaluated with c_in = 0.
//   - Invariant: {c_out, sum} == a + b + c_in, as a 6-bit unsigned value, for all 2048 input combinations.
//   - Latency: 1 clock. Inputs sampled at edge N appear on the outputs after edge N.
//   - Throughput: a new operand set is accepted every cycle. There is no handshake and no stall.
//   - Overflow: wraps mod 32 in sum, with c_out = 1. No saturation and no flags.
//   - Reset release: the first edge with rst_n = 1 loads the current inputs.
//   - Reset asserted mid-stream: outputs clear immediately; any in-flight result is discarded.
//   - X/Z on inputs is not handled specially.
// STRUCTURE
//   - Shared package: none needed. WIDTH is a localparam in this file.
//   - Sub-module cla_pg_cell (one instance per bit): takes a and b bits, returns p and g.
//   - Lookahead carry logic, sum XORs and the output register live in cla_5_bit.
//   - Combinational core and registers are kept in separate always blocks.
// TESTING
//   - Reset: hold rst_n = 0 with random a/b -> all outputs 0. Release -> next edge loads the result.
//   - Exhaustive: drive a, b over 0..31 x 0..31 with c_in = 0, then repeat with c_in = 1.
//     Each cycle -> {c_out, sum} == a + b + c_in one cycle later. Stop on the first mismatch.
//   - Corners:
//     0 + 0 + 0 -> sum 0, c_out 0.
//     31 + 1 + 0 -> sum 0, c_out 1.
//     31 + 31 + 1 -> sum 31, c_out 1.
//     21 + 10 + 0 -> sum 31, c_out 0, grp_p 1.
//   - Full propagate: a = 31, b = 0, c_in = 1 -> sum 0, c_out 1, grp_p 1, grp_g 0.
//   - Mid-stream reset: assert rst_n = 0 between edges while sum = 31 -> outputs drop to 0 at once.
//     Back-to-back operands after release each -> correct with 1-cycle latency.

Source files
------------

// File: rtl/cla_pg_cell.sv
// Per-bit propagate/generate cell for the 5-bit carry-lookahead adder.
module cla_pg_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_p,
    output logic o_g
);

    // Propagate when exactly one operand bit is set, generate when both are.
    always_comb begin
        o_p = i_a ^ i_b;
        o_g = i_a & i_b;
    end

endmodule

// File: rtl/cla_5_bit.sv
// 5-bit carry-lookahead adder with registered sum, carry-out and group P/G.
// Every carry is a flat two-level sum-of-products over g, p and c_in.
module cla_5_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       c_in,
    output logic [4:0] sum,
    output logic       c_out,
    output logic       grp_p,
    output logic       grp_g
);

    localparam int unsigned WIDTH = 5;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic             w_grp_p;
    logic             w_grp_g;

    // One propagate/generate cell per operand bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg
        cla_pg_cell u_pg (
            .i_a (a[gi]),
            .i_b (b[gi]),
            .o_p (w_p[gi]),
            .o_g (w_g[gi])
        );
    end

    // Lookahead carries, group terms and sum bits; no carry feeds another carry.
    always_comb begin
        w_c     = '0;
        w_s     = '0;
        w_grp_p = 1'b0;
        w_grp_g = 1'b0;

        w_c[0] = c_in;

        w_c[1] = w_g[0]
               | (w_p[0] & c_in);

        w_c[2] = w_g[1]
               | (w_p[1] & w_g[0])
               | (w_p[1] & w_p[0] & c_in);

        w_c[3] = w_g[2]
               | (w_p[2] & w_g[1])
               | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & c_in);

        w_c[4] = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);

        // Group generate is the carry-out with c_in forced to zero.
        w_grp_g = w_g[4]
                | (w_p[4] & w_g[3])
                | (w_p[4] & w_p[3] & w_g[2])
                | (w_p[4] & w_p[3] & w_p[2] & w_g[1])
                | (w_p[4] & w_p[3] & w_p[2] & w_p[1] & w_g[0]);

        w_grp_p = &w_p;

        w_c[5] = w_g[4]
               | (w_p[4] & w_g[3])
               | (w_p[4] & w_p[3] & w_g[2])
               | (w_p[4] & w_p[3] & w_p[2] & w_g[1])
               | (w_p[4] & w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[4] & w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);

        w_s = w_p ^ w_c[WIDTH-1:0];
    end

    // Output register; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            c_out <= 1'b0;
            grp_p <= 1'b0;
            grp_g <= 1'b0;
        end else begin
            sum   <= w_s;
            c_out <= w_c[WIDTH];
            grp_p <= w_grp_p;
            grp_g <= w_grp_g;
        end
    end

endmodule

// File: tb/tb_cla_5_bit.sv
// Scoreboard bench for cla_5_bit: expected results queued at drive time,
// popped and compared one clock later.
module tb_cla_5_bit;

    logic       clk;
    logic       rst_n;
    logic [4:0] a;
    logic [4:0] b;
    logic       c_in;
    logic [4:0] sum;
    logic       c_out;
    logic       grp_p;
    logic       grp_g;

    typedef struct packed {
        logic [4:0] sum;
        logic       c_out;
        logic       grp_p;
        logic       grp_g;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    cla_5_bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out),
        .grp_p (grp_p),
        .grp_g (grp_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (a=%0d b=%0d c_in=%0d)", tag, got, exp, a, b, c_in);
        end
    endtask

    // Reference model built from plain integer arithmetic.
    function automatic exp_t model(input logic [4:0] ma, input logic [4:0] mb, input logic mc);
        exp_t       e;
        logic [5:0] full;
        logic [5:0] nocin;
        full    = 6'(ma) + 6'(mb) + 6'(mc);
        nocin   = 6'(ma) + 6'(mb);
        e.sum   = full[4:0];
        e.c_out = full[5];
        e.grp_p = &(ma ^ mb);
        e.grp_g = nocin[5];
        return e;
    endfunction

    task automatic drive(input logic [4:0] da, input logic [4:0] db, input logic dc);
        a    = da;
        b    = db;
        c_in = dc;
        exp_q.push_back(model(da, db, dc));
    endtask

    // Advance one edge and compare the oldest queued result.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sum",   8'(sum),   8'(e.sum));
            chk("c_out", 8'(c_out), 8'(e.c_out));
            chk("grp_p", 8'(grp_p), 8'(e.grp_p));
            chk("grp_g", 8'(grp_g), 8'(e.grp_g));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sum"},   8'(sum),   8'd0);
        chk({tag, "_c_out"}, 8'(c_out), 8'd0);
        chk({tag, "_grp_p"}, 8'(grp_p), 8'd0);
        chk({tag, "_grp_g"}, 8'(grp_g), 8'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        c_in     = 1'b0;

        // Reset held with random operands: outputs stay zero across edges.
        for (int i = 0; i < 4; i++) begin
            a    = 5'($urandom_range(31));
            b    = 5'($urandom_range(31));
            c_in = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            chk_zero("rst_hold");
        end

        // Release between edges; the next edge loads the current operands.
        rst_n = 1'b1;
        drive(5'd17, 5'd22, 1'b1);
        tick();

        // Corner cases and full propagate.
        drive(5'd0,  5'd0,  1'b0); tick();
        drive(5'd31, 5'd1,  1'b0); tick();
        drive(5'd31, 5'd31, 1'b1); tick();
        drive(5'd21, 5'd10, 1'b0); tick();
        drive(5'd31, 5'd0,  1'b1); tick();

        // Exhaustive sweep, one operand set per cycle; stop issuing on first error.
        for (int ci = 0; ci < 2; ci++) begin
            for (int ia = 0; ia < 32; ia++) begin
                for (int ib = 0; ib < 32; ib++) begin
                    if (n_errors == 0) begin
                        drive(5'(ia), 5'(ib), 1'(ci));
                        tick();
                    end
                end
            end
        end

        // Mid-stream reset: sum is 31, another result is in flight.
        drive(5'd31, 5'd0, 1'b0);
        tick();
        drive(5'd5, 5'd6, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst_async");
        exp_q.delete();
        @(posedge clk);
        #1;
        chk_zero("mid_rst_edge");

        // Back-to-back operands after release.
        rst_n = 1'b1;
        drive(5'd3,  5'd4,  1'b0); tick();
        drive(5'd16, 5'd16, 1'b1); tick();
        drive(5'd9,  5'd22, 1'b0); tick();
        drive(5'd30, 5'd1,  1'b1); tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
